tx_byte_ctrl: RTL and testbench

TX_BYTE_CTRL -- requirements
Module: tx_byte_ctrl

---
 rtl/i2c_pkg.sv | 17 +
 rtl/flex_pts_sr.sv | 39 +++
 rtl/tx_byte_ctrl.sv | 110 +++++++++++
 tb/tb_tx_byte_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte-level blocks.
//   tx_state_t : state encoding of the byte transmitter controller
//   ACK / NACK : level sampled on SDA during the acknowledge slot
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRIVE    = 3'd1,
        ACK_REL  = 3'd2,
        ACK_HOLD = 3'd3,
        DONE     = 3'd4
    } tx_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// Flexible parallel-to-serial shift register.
// Ports:
//   clk          - system clock, rising edge
//   n_rst        - asynchronous active-low reset, all bits set to 1
//   shift_enable - advance one bit, vacated position filled with 1
//   load_enable  - capture parallel_in (wins over shift_enable)
//   parallel_in  - NUM_BITS word to serialize
//   serial_out   - current bit (MSB when SHIFT_MSB=1, else LSB)
module flex_pts_sr #(
    parameter int unsigned NUM_BITS  = 8,
    parameter bit          SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                load_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out
);

    logic [NUM_BITS-1:0] q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q <= '1;
        end else if (load_enable) begin
            q <= parallel_in;
        end else if (shift_enable) begin
            // Fill with 1 so an over-shifted register reads as a released line
            if (SHIFT_MSB)
                q <= {q[NUM_BITS-2:0], 1'b1};
            else
                q <= {1'b1, q[NUM_BITS-1:1]};
        end
    end

    assign serial_out = SHIFT_MSB ? q[NUM_BITS-1] : q[0];

endmodule

// File: rtl/tx_byte_ctrl.sv
// I2C byte transmitter controller: serializes one word onto SDA, one bit per
// SCL low phase, then releases SDA for the acknowledge slot and records the
// receiver's ACK/NACK.
// Ports:
//   clk, n_rst - system clock / asynchronous active-low reset
//   tx_start   - request to send tx_data (accepted only in IDLE)
//   tx_data    - word to send, captured when tx_start is accepted
//   scl_rise   - one-cycle pulse at an SCL rising edge
//   scl_fall   - one-cycle pulse at an SCL falling edge
//   sda_in     - synchronized SDA level, sampled at the ACK rise
//   abort      - cancel the current transfer, back to IDLE
//   sda_out    - SDA drive value (1 = released)
//   busy       - controller not in IDLE
//   tx_done    - one-cycle pulse when word plus ACK slot completed
//   nack       - ACK result of the last completed word (1 = NACK)
module tx_byte_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_BITS  = 8,
    parameter bit          SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                tx_start,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                scl_rise,
    input  logic                scl_fall,
    input  logic                sda_in,
    input  logic                abort,
    output logic                sda_out,
    output logic                busy,
    output logic                tx_done,
    output logic                nack
);

    localparam int unsigned     CNT_W    = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] bit_cnt;
    logic             load_enable;
    logic             shift_enable;
    logic             serial_bit;

    // Abort dominates everything, so it also blocks a load or shift in the
    // same cycle. The last bit is not shifted out: the ACK slot releases SDA
    // by state instead.
    assign load_enable  = (state == IDLE) && tx_start && !abort;
    assign shift_enable = (state == DRIVE) && scl_fall && !abort &&
                          (bit_cnt != LAST_BIT);

    flex_pts_sr #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (SHIFT_MSB)
    ) u_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_enable),
        .load_enable  (load_enable),
        .parallel_in  (tx_data),
        .serial_out   (serial_bit)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            nack    <= ACK;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        state   <= DRIVE;
                        bit_cnt <= '0;
                    end
                end
                DRIVE: begin
                    if (scl_fall) begin
                        if (bit_cnt == LAST_BIT)
                            state <= ACK_REL;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ACK_REL: begin
                    // A coincident fall masks the rise
                    if (scl_rise && !scl_fall) begin
                        nack  <= sda_in;
                        state <= ACK_HOLD;
                    end
                end
                ACK_HOLD: begin
                    if (scl_fall)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only registered state and the registered shift bit,
    // so none of them has a combinational path from an input.
    assign sda_out = (state == DRIVE) ? serial_bit : 1'b1;
    assign busy    = (state != IDLE);
    assign tx_done = (state == DONE);

endmodule

// File: tb/tb_tx_byte_ctrl.sv
module tb_tx_byte_ctrl;

    logic       clk      = 1'b0;
    logic       n_rst    = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       scl_rise = 1'b0;
    logic       scl_fall = 1'b0;
    logic       sda_in   = 1'b1;
    logic       abort    = 1'b0;

    logic sda_m, busy_m, done_m, nack_m;
    logic sda_l, busy_l, done_l, nack_l;

    int   passed     = 0;
    int   total      = 0;
    int   done_cnt_m = 0;
    int   done_cnt_l = 0;
    logic exp_nack   = 1'b0;

    always #5 clk = ~clk;

    tx_byte_ctrl #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) dut_msb (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .sda_in(sda_in), .abort(abort),
        .sda_out(sda_m), .busy(busy_m), .tx_done(done_m), .nack(nack_m)
    );

    tx_byte_ctrl #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut_lsb (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .sda_in(sda_in), .abort(abort),
        .sda_out(sda_l), .busy(busy_l), .tx_done(done_l), .nack(nack_l)
    );

    always @(posedge clk) begin
        if (done_m === 1'b1) done_cnt_m = done_cnt_m + 1;
        if (done_l === 1'b1) done_cnt_l = done_cnt_l + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Bit i of the serial stream, taken straight from the word
    function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb_first);
        return msb_first ? w[7-i] : w[i];
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic check_bit(input string tag, input logic [7:0] w, input int i);
        check($sformatf("%s_msb_b%0d", tag, i), sda_m, exp_bit(w, i, 1'b1));
        check($sformatf("%s_lsb_b%0d", tag, i), sda_l, exp_bit(w, i, 1'b0));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy_m"}, busy_m, 0);
        check({tag, "_busy_l"}, busy_l, 0);
        check({tag, "_sda_m"},  sda_m,  1);
        check({tag, "_sda_l"},  sda_l,  1);
        check({tag, "_done_m"}, done_m, 0);
        check({tag, "_done_l"}, done_l, 0);
        check({tag, "_nack_m"}, nack_m, exp_nack);
        check({tag, "_nack_l"}, nack_l, exp_nack);
    endtask

    // One word: 8 data bits, optional abort after N falls, optional ignored
    // restart after N falls, then the ACK slot with receiver level a.
    task automatic run_word(input string tag, input logic [7:0] w, input logic a,
                            input int abort_after, input int restart_after);
        int dm0;
        int dl0;
        dm0 = done_cnt_m;
        dl0 = done_cnt_l;
        tx_data = w; tx_start = 1'b1; step(); tx_start = 1'b0; tx_data = 8'($urandom);
        check({tag, "_busy_start_m"}, busy_m, 1);
        check({tag, "_busy_start_l"}, busy_l, 1);
        for (int i = 0; i < 8; i++) begin
            check_bit({tag, "_low"}, w, i);
            gap(); scl_rise = 1'b1; step(); scl_rise = 1'b0;
            check_bit({tag, "_high"}, w, i);
            gap(); scl_fall = 1'b1; step(); scl_fall = 1'b0;
            if (i + 1 == abort_after) begin
                abort = 1'b1; step(); abort = 1'b0;
                check_idle({tag, "_abort"});
                step();
                check_idle({tag, "_abort_hold"});
                check({tag, "_abort_done_cnt_m"}, done_cnt_m - dm0, 0);
                check({tag, "_abort_done_cnt_l"}, done_cnt_l - dl0, 0);
                return;
            end
            if (i + 1 == restart_after) begin
                tx_data = ~w; tx_start = 1'b1; step(); tx_start = 1'b0;
            end
        end
        check({tag, "_ackrel_sda_m"}, sda_m, 1);
        check({tag, "_ackrel_sda_l"}, sda_l, 1);
        check({tag, "_ackrel_busy_m"}, busy_m, 1);
        // Coincident rise+fall: the rise must be ignored, nack keeps old value
        sda_in = ~a; scl_rise = 1'b1; scl_fall = 1'b1; step();
        scl_rise = 1'b0; scl_fall = 1'b0;
        check({tag, "_both_nack_m"}, nack_m, exp_nack);
        check({tag, "_both_nack_l"}, nack_l, exp_nack);
        check({tag, "_both_busy_m"}, busy_m, 1);
        gap(); sda_in = a; scl_rise = 1'b1; step(); scl_rise = 1'b0; sda_in = 1'($urandom);
        exp_nack = a;
        check({tag, "_ack_nack_m"}, nack_m, exp_nack);
        check({tag, "_ack_nack_l"}, nack_l, exp_nack);
        check({tag, "_ack_done_m"}, done_m, 0);
        gap(); scl_fall = 1'b1; step(); scl_fall = 1'b0;
        check({tag, "_done_m"}, done_m, 1);
        check({tag, "_done_l"}, done_l, 1);
        check({tag, "_done_busy_m"}, busy_m, 1);
        check({tag, "_done_sda_m"}, sda_m, 1);
        // A start during the DONE cycle must be dropped
        tx_start = 1'b1; tx_data = 8'($urandom); step(); tx_start = 1'b0;
        check_idle({tag, "_post"});
        step();
        check_idle({tag, "_post2"});
        check({tag, "_done_cnt_m"}, done_cnt_m - dm0, 1);
        check({tag, "_done_cnt_l"}, done_cnt_l - dl0, 1);
    endtask

    task automatic reset_mid_word(input logic [7:0] w);
        tx_data = w; tx_start = 1'b1; step(); tx_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_bit("rst_pre", w, i);
            scl_rise = 1'b1; step(); scl_rise = 1'b0;
            scl_fall = 1'b1; step(); scl_fall = 1'b0;
        end
        #1 n_rst = 1'b0;
        #1;
        exp_nack = 1'b0;
        check_idle("rst_async");
        step(); #1 n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); scl_rise = 1'b1; step(); scl_rise = 1'b0;
            scl_fall = 1'b1; step(); scl_fall = 1'b0;
            check_idle($sformatf("rst_after_%0d", i));
        end
    endtask

    initial begin
        logic [7:0] w;
        step(); step();
        check_idle("reset");
        #1 n_rst = 1'b1;
        step();
        check_idle("reset_release");

        run_word("a5",  8'hA5, 1'b0, -1, -1);
        run_word("3c",  8'h3C, 1'b1, -1, -1);
        run_word("01",  8'h01, 1'b0, -1, -1);
        run_word("ff",  8'hFF, 1'b1, -1,  3);
        run_word("abt", 8'h96, 1'b0,  4, -1);
        reset_mid_word(8'h00);
        for (int k = 0; k < 6; k++) begin
            w = 8'($urandom);
            run_word($sformatf("rnd%0d", k), w, 1'($urandom), -1, -1);
        end
        w = 8'($urandom);
        run_word("rnd_abt", w, 1'b1, int'($urandom_range(1, 7)), -1);
        run_word("final", 8'h5A, 1'b1, -1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
